// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type, funct3 codes and access-fault helper
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A load/store that must never reach the bus: unsupported width code or
  // an address that is not aligned to the access size.
  function automatic logic access_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_load,
                                        input logic       is_store);
    logic illegal;
    logic misal;
    illegal = 1'b0;
    misal   = 1'b0;
    if (is_store && !(funct3 inside {F3_B, F3_H, F3_W}))
      illegal = 1'b1;
    if (is_load && !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      illegal = 1'b1;
    case (funct3)
      F3_H, F3_HU: misal = addr_lo[0];
      F3_W:        misal = (addr_lo != 2'b00);
      default:     misal = 1'b0;
    endcase
    return (is_load || is_store) && (illegal || misal);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/ack data-memory bus between M stage and memory
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane strobes, store replication, load extension, fault detect
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
  assign fault    = access_fault(funct3, addr_lo, is_load, is_store);

  // Store path: replicate the narrow datum on every lane and enable only the addressed ones.
  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          wstrb = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        F3_W:    wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end
  end

  // Load path: pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM pipeline register and data-memory access controller
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ALUResultE,
  input  logic [31:0]          WriteDataE,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemReadE,
  input  logic                 MemWriteE,
  input  logic [2:0]           funct3E,
  output logic [31:0]          ALUResultM,
  output logic [4:0]           RdM,
  output logic                 RegWriteM,
  output logic [31:0]          ReadDataM,
  output logic                 StallM,
  output logic                 misalignedM,
  output logic                 bus_errM,
  mem_access_stage_if.master   dmem
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t  state;
  logic [CW-1:0] wait_cnt;
  logic [31:0] alu_m;
  logic [31:0] wd_m;
  logic [4:0]  rd_m;
  logic        regw_m;
  logic        mr_m;
  logic        mw_m;
  logic [2:0]  f3_m;
  logic [31:0] rdata_m;
  logic        berr_m;

  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic        fault_m;
  logic        fault_e;
  logic        memop_e;
  logic        in_access;

  assign memop_e   = MemReadE | MemWriteE;
  assign fault_e   = access_fault(funct3E, ALUResultE[1:0], MemReadE, MemWriteE);
  assign in_access = (state == ACCESS);

  lsu_lane_align u_align (
    .funct3     (f3_m),
    .addr_lo    (alu_m[1:0]),
    .is_load    (mr_m),
    .is_store   (mw_m),
    .store_data (wd_m),
    .rdata      (dmem.dmem_rdata),
    .wstrb      (lane_strb),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .fault      (fault_m)
  );

  // Pipeline register capture plus IDLE/ACCESS/DONE sequencing of the bus access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      alu_m    <= '0;
      wd_m     <= '0;
      rd_m     <= '0;
      regw_m   <= 1'b0;
      mr_m     <= 1'b0;
      mw_m     <= 1'b0;
      f3_m     <= '0;
      rdata_m  <= '0;
      berr_m   <= 1'b0;
    end else begin
      case (state)
        ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          // An ack in the timeout cycle still completes the access normally.
          if (dmem.dmem_ack) begin
            rdata_m <= mr_m ? load_data : '0;
            state   <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rdata_m <= '0;
            berr_m  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          alu_m    <= ALUResultE;
          wd_m     <= WriteDataE;
          rd_m     <= RdE;
          regw_m   <= RegWriteE;
          mr_m     <= MemReadE;
          mw_m     <= MemWriteE;
          f3_m     <= funct3E;
          rdata_m  <= '0;
          berr_m   <= 1'b0;
          wait_cnt <= '0;
          if (memop_e && !fault_e)
            state <= ACCESS;
          else if (memop_e)
            state <= DONE;
          else
            state <= IDLE;
        end
      endcase
    end
  end

  assign ALUResultM  = alu_m;
  assign RdM         = rd_m;
  assign ReadDataM   = rdata_m;
  assign StallM      = in_access;
  assign misalignedM = fault_m;
  assign RegWriteM   = regw_m & ~fault_m & ~berr_m;
  assign bus_errM    = berr_m & (state == DONE);

  assign dmem.dmem_req   = in_access;
  assign dmem.dmem_we    = in_access & mw_m;
  assign dmem.dmem_addr  = {alu_m[31:2], 2'b00};
  assign dmem.dmem_wdata = lane_wdata;
  assign dmem.dmem_wstrb = in_access ? lane_strb : 4'b0000;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultE, WriteDataE;
  logic [4:0]  RdE;
  logic        RegWriteE, MemReadE, MemWriteE;
  logic [2:0]  funct3E;
  logic [31:0] ALUResultM, ReadDataM;
  logic [4:0]  RdM;
  logic        RegWriteM, StallM, misalignedM, bus_errM;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUResultE  (ALUResultE),
    .WriteDataE  (WriteDataE),
    .RdE         (RdE),
    .RegWriteE   (RegWriteE),
    .MemReadE    (MemReadE),
    .MemWriteE   (MemWriteE),
    .funct3E     (funct3E),
    .ALUResultM  (ALUResultM),
    .RdM         (RdM),
    .RegWriteM   (RegWriteM),
    .ReadDataM   (ReadDataM),
    .StallM      (StallM),
    .misalignedM (misalignedM),
    .bus_errM    (bus_errM),
    .dmem        (dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
    logic        regw;
    logic        berr;
    int          stall;
    logic        is_load;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_fault(input logic [2:0] f3, input logic [1:0] a,
                                   input logic mr, input logic mw);
    logic legal_ld, legal_st, mis;
    legal_ld = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    legal_st = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    mis      = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a != 2'd0);
    return (mr && !legal_ld) || (mw && !legal_st) || ((mr || mw) && mis);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [31:0] sh;
    logic [15:0] h;
    sh = d >> (a * 8);
    h  = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'd0:    return sh[7] ? (32'hFFFFFF00 | sh[7:0]) : {24'h0, sh[7:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd5:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'd0:    return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 :
                      (a == 2'd2) ? 4'b0100 : 4'b1000;
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic nop_inputs();
    ALUResultE = '0; WriteDataE = '0; RdE = '0; RegWriteE = 1'b0;
    MemReadE = 1'b0; MemWriteE = 1'b0; funct3E = '0;
  endtask

  // Issue one instruction from EX; ack_at = ACCESS cycle carrying the ack, 0 = never.
  task automatic op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                    input logic [4:0] rd, input logic regw, input logic mr, input logic mw,
                    input logic [2:0] f3, input int ack_at, input logic [31:0] rdata);
    exp_t e;
    logic flt, memop;
    int   stall;
    flt     = m_fault(f3, alu[1:0], mr, mw);
    memop   = mr | mw;
    e.tag   = tag;
    e.mis   = memop && flt;
    e.stall = (memop && !flt) ? ((ack_at == 0) ? 64 : ack_at) : 0;
    e.berr  = memop && !flt && (ack_at == 0);
    e.regw  = regw && !e.mis && !e.berr;
    e.is_load = mr;
    e.rdata = (mr && !flt && ack_at != 0) ? m_load(f3, alu[1:0], rdata) : 32'h0;
    sb.push_back(e);

    ALUResultE = alu; WriteDataE = wd; RdE = rd; RegWriteE = regw;
    MemReadE = mr; MemWriteE = mw; funct3E = f3;
    @(posedge clk); #1;
    nop_inputs();
    chk({tag, ".alu_m"}, ALUResultM, alu);
    chk({tag, ".rd_m"}, {27'h0, RdM}, {27'h0, rd});

    stall = 0;
    while (StallM === 1'b1 && stall < 200) begin
      stall++;
      chk({tag, ".req"}, {31'h0, dmem.dmem_req}, 32'h1);
      chk({tag, ".addr"}, dmem.dmem_addr, {alu[31:2], 2'b00});
      chk({tag, ".wstrb"}, {28'h0, dmem.dmem_wstrb}, {28'h0, (mw ? m_strb(f3, alu[1:0]) : 4'b0000)});
      chk({tag, ".we"}, {31'h0, dmem.dmem_we}, {31'h0, mw});
      if (mw) chk({tag, ".wdata"}, dmem.dmem_wdata, m_wdata(f3, wd));
      if (stall == ack_at) begin
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = $urandom;
    end

    e = sb.pop_front();
    chk({e.tag, ".stall_cycles"}, 32'(stall), 32'(e.stall));
    chk({e.tag, ".req_off"}, {31'h0, dmem.dmem_req}, 32'h0);
    chk({e.tag, ".wstrb_off"}, {28'h0, dmem.dmem_wstrb}, 32'h0);
    chk({e.tag, ".misaligned"}, {31'h0, misalignedM}, {31'h0, e.mis});
    chk({e.tag, ".regwrite"}, {31'h0, RegWriteM}, {31'h0, e.regw});
    chk({e.tag, ".bus_err"}, {31'h0, bus_errM}, {31'h0, e.berr});
    if (e.is_load) chk({e.tag, ".rdata"}, ReadDataM, e.rdata);
  endtask

  initial begin
    rst = 1'b1;
    nop_inputs();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall", {31'h0, StallM}, 32'h0);
    chk("reset.req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("reset.alu_m", ALUResultM, 32'h0);
    chk("reset.regwrite", {31'h0, RegWriteM}, 32'h0);
    chk("reset.rdata", ReadDataM, 32'h0);
    rst = 1'b0;

    op("add",   32'h0000_1234, 32'h0,         5'd3,  1'b1, 1'b0, 1'b0, 3'd2, 0, 32'h0);
    // Ack while idle must not disturb anything.
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b0;
    chk("idle_ack.stall", {31'h0, StallM}, 32'h0);
    chk("idle_ack.rdata", ReadDataM, 32'h0);

    op("sw",    32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 1'b1, 3'd2, 1, 32'h0);
    op("lb",    32'h0000_0203, 32'h0,         5'd4,  1'b1, 1'b1, 1'b0, 3'd0, 1, 32'h80AA_BBCC);
    op("lbu",   32'h0000_0203, 32'h0,         5'd5,  1'b1, 1'b1, 1'b0, 3'd4, 1, 32'h80AA_BBCC);
    op("lhu",   32'h0000_0302, 32'h0,         5'd6,  1'b1, 1'b1, 1'b0, 3'd5, 3, 32'hBEEF_1234);
    op("lh",    32'h0000_0300, 32'h0,         5'd7,  1'b1, 1'b1, 1'b0, 3'd1, 2, 32'h1234_8001);
    op("sb",    32'h0000_0101, 32'h0000_00A5, 5'd0,  1'b0, 1'b0, 1'b1, 3'd0, 1, 32'h0);
    op("sh",    32'h0000_0102, 32'h0000_CAFE, 5'd0,  1'b0, 1'b0, 1'b1, 3'd1, 2, 32'h0);
    op("lw_mis",32'h0000_0101, 32'h0,         5'd8,  1'b1, 1'b1, 1'b0, 3'd2, 1, 32'h0);
    op("sh_mis",32'h0000_0003, 32'h1111_2222, 5'd0,  1'b0, 1'b0, 1'b1, 3'd1, 1, 32'h0);
    op("ld_ill",32'h0000_0000, 32'h0,         5'd9,  1'b1, 1'b1, 1'b0, 3'd3, 1, 32'h0);
    op("st_ill",32'h0000_0000, 32'h0,         5'd0,  1'b0, 1'b0, 1'b1, 3'd4, 1, 32'h0);
    op("lw_to", 32'h0000_0500, 32'h0,         5'd10, 1'b1, 1'b1, 1'b0, 3'd2, 0, 32'h0);
    op("lw_ok", 32'h0000_0504, 32'h0,         5'd11, 1'b1, 1'b1, 1'b0, 3'd2, 2, 32'h1234_5678);
    op("lw_late",32'h0000_0508, 32'h0,        5'd12, 1'b1, 1'b1, 1'b0, 3'd2, 64, 32'hCAFE_F00D);

    // Reset in the middle of an outstanding load.
    ALUResultE = 32'h0000_0400; RdE = 5'd13; RegWriteE = 1'b1; MemReadE = 1'b1; funct3E = 3'd2;
    @(posedge clk); #1;
    nop_inputs();
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.stall_before", {31'h0, StallM}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rst_mid.stall", {31'h0, StallM}, 32'h0);
    chk("rst_mid.alu_m", ALUResultM, 32'h0);
    chk("rst_mid.rd_m", {27'h0, RdM}, 32'h0);
    chk("rst_mid.regwrite", {31'h0, RegWriteM}, 32'h0);
    chk("rst_mid.rdata", ReadDataM, 32'h0);
    chk("rst_mid.addr", dmem.dmem_addr, 32'h0);
    chk("rst_mid.wstrb", {28'h0, dmem.dmem_wstrb}, 32'h0);
    chk("rst_mid.misaligned", {31'h0, misalignedM}, 32'h0);
    chk("rst_mid.bus_err", {31'h0, bus_errM}, 32'h0);
    rst = 1'b0;

    op("post_rst", 32'h0000_0601, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'd4, 1, 32'h0000_7F00);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
